// File: rtl/carrier_nco_if.sv
// rtl/carrier_nco_if.sv - loop-side bundle between the carrier loop filter/mixers and the NCO
interface carrier_nco_if #(
  parameter int ACC_W  = 24,
  parameter int DATA_W = 16
);
  logic                     en;
  logic                     clr;
  logic [ACC_W-1:0]         freq_err;
  logic [ACC_W-1:0]         phase_o;
  logic signed [DATA_W-1:0] sin_o;
  logic signed [DATA_W-1:0] cos_o;
  logic                     valid_o;

  modport master (
    output en, clr, freq_err,
    input  phase_o, sin_o, cos_o, valid_o
  );

  modport slave (
    input  en, clr, freq_err,
    output phase_o, sin_o, cos_o, valid_o
  );
endinterface

// File: rtl/carrier_nco.sv
// rtl/carrier_nco.sv - carrier-sync NCO: phase accumulator, quarter-wave sin/cos ROM, 4-stage pipe
// Optional phase dither before truncation is built when NCO_DITHER_EN is defined.
module carrier_nco #(
  parameter int              ACC_W      = 24,
  parameter int              LUT_AW     = 8,
  parameter int              DATA_W     = 16,
  parameter logic [ACC_W-1:0] CENTER_FCW = ACC_W'(24'h400000)
) (
  input logic          clk,
  input logic          rst_n,
  carrier_nco_if.slave bus
);
  localparam int     ROM_N  = 2 ** LUT_AW;
  localparam longint FX_ONE = 64'sd1073741824;
  localparam longint FX_PI  = 64'sd3373259426;
  localparam longint AMP    = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;

  // Entry k = round(AMP * sin((k+0.5)*pi/2^(LUT_AW+1))), evaluated at elaboration in Q30 via Horner Taylor series.
  function automatic logic [ROM_N*DATA_W-1:0] build_rom();
    logic [ROM_N*DATA_W-1:0] img;
    longint x, x2, t, s, v;
    img = '0;
    for (int k = 0; k < ROM_N; k++) begin
      x  = (longint'(2 * k + 1) * FX_PI) >>> (LUT_AW + 2);
      x2 = (x * x) >>> 30;
      t  = FX_ONE;
      for (int n = 8; n >= 1; n--) begin
        t = FX_ONE - ((x2 * t) >>> 30) / longint'((2 * n) * (2 * n + 1));
      end
      s = (x * t) >>> 30;
      v = (s * AMP + (FX_ONE >>> 1)) >>> 30;
      img[k*DATA_W +: DATA_W] = DATA_W'(v);
    end
    return img;
  endfunction

  localparam logic [ROM_N*DATA_W-1:0] ROM_IMG = build_rom();

  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         step;
  logic [ACC_W-1:0]         s1_ph;
  logic                     s1_v;
  logic [LUT_AW+1:0]        s1_idx;
  logic [1:0]               s2_q;
  logic [LUT_AW-1:0]        s2_a;
  logic [LUT_AW-1:0]        s2_abar;
  logic [ACC_W-1:0]         s2_ph;
  logic                     s2_v;
  logic [1:0]               s3_q;
  logic signed [DATA_W-1:0] r_a;
  logic signed [DATA_W-1:0] r_abar;
  logic [ACC_W-1:0]         s3_ph;
  logic                     s3_v;
  logic signed [DATA_W-1:0] sin_n;
  logic signed [DATA_W-1:0] cos_n;

  assign step = CENTER_FCW + bus.freq_err;

  // S0: the sample carries the pre-increment phase, so the first one after reset/clr is phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      s1_ph <= '0;
      s1_v  <= 1'b0;
    end else if (bus.clr) begin
      acc  <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= bus.en;
      if (bus.en) begin
        s1_ph <= acc;
        acc   <= acc + step;
      end
    end
  end

`ifdef NCO_DITHER_EN
  localparam int               TRUNC_W   = ACC_W - LUT_AW - 2;
  localparam logic [ACC_W-1:0] DITH_MASK = (ACC_W'(1) << TRUNC_W) - ACC_W'(1);

  logic [15:0]      lfsr;
  logic [ACC_W-1:0] s1_dith;
  logic [ACC_W-1:0] ph_dith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= 16'hACE1;
      s1_dith <= '0;
    end else if (bus.clr) begin
      lfsr <= 16'hACE1;
    end else if (bus.en) begin
      s1_dith <= ACC_W'(lfsr) & DITH_MASK;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign ph_dith = s1_ph + s1_dith;
  assign s1_idx  = ph_dith[ACC_W-1 -: LUT_AW+2];
`else
  assign s1_idx = s1_ph[ACC_W-1 -: LUT_AW+2];
`endif

  // Data stages free-run; only the valid chain decides what reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q    <= '0;
      s2_a    <= '0;
      s2_abar <= '0;
      s2_ph   <= '0;
      s3_q    <= '0;
      s3_ph   <= '0;
      r_a     <= '0;
      r_abar  <= '0;
    end else begin
      s2_q    <= s1_idx[LUT_AW+1 -: 2];
      s2_a    <= s1_idx[LUT_AW-1:0];
      s2_abar <= ~s1_idx[LUT_AW-1:0];
      s2_ph   <= s1_ph;
      s3_q    <= s2_q;
      s3_ph   <= s2_ph;
      r_a     <= ROM_IMG[int'(s2_a)*DATA_W +: DATA_W];
      r_abar  <= ROM_IMG[int'(s2_abar)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    sin_n = r_a;
    cos_n = r_abar;
    case (s3_q)
      2'd0: begin sin_n = r_a;     cos_n = r_abar;  end
      2'd1: begin sin_n = r_abar;  cos_n = -r_a;    end
      2'd2: begin sin_n = -r_a;    cos_n = -r_abar; end
      2'd3: begin sin_n = -r_abar; cos_n = r_a;     end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      s3_v        <= 1'b0;
      bus.valid_o <= 1'b0;
    end else if (bus.clr) begin
      s2_v        <= 1'b0;
      s3_v        <= 1'b0;
      bus.valid_o <= 1'b0;
    end else begin
      s2_v        <= s1_v;
      s3_v        <= s2_v;
      bus.valid_o <= s3_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.phase_o <= '0;
      bus.sin_o   <= '0;
      bus.cos_o   <= '0;
    end else if (s3_v && !bus.clr) begin
      bus.phase_o <= s3_ph;
      bus.sin_o   <= sin_n;
      bus.cos_o   <= cos_n;
    end
  end
endmodule

// File: tb/tb_carrier_nco.sv
// tb/tb_carrier_nco.sv - directed bench for carrier_nco with a real-math reference model
module tb_carrier_nco;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] freq_err = '0;
  logic        chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  carrier_nco_if #(.ACC_W(24), .DATA_W(16)) bus_a ();
  carrier_nco_if #(.ACC_W(24), .DATA_W(16)) bus_w ();

  assign bus_a.en = en;
  assign bus_a.clr = clr;
  assign bus_a.freq_err = freq_err;
  assign bus_w.en = en;
  assign bus_w.clr = clr;
  assign bus_w.freq_err = freq_err;

  carrier_nco #(.ACC_W(24), .LUT_AW(8), .DATA_W(16), .CENTER_FCW(24'h400000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  carrier_nco #(.ACC_W(24), .LUT_AW(8), .DATA_W(16), .CENTER_FCW(24'hFFFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w)
  );

  logic [23:0]        ph_o [2];
  logic signed [15:0] s_o [2];
  logic signed [15:0] c_o [2];
  logic               v_o [2];
  assign ph_o[0] = bus_a.phase_o;
  assign ph_o[1] = bus_w.phase_o;
  assign s_o[0]  = bus_a.sin_o;
  assign s_o[1]  = bus_w.sin_o;
  assign c_o[0]  = bus_a.cos_o;
  assign c_o[1]  = bus_w.cos_o;
  assign v_o[0]  = bus_a.valid_o;
  assign v_o[1]  = bus_w.valid_o;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(-x + 0.5));
  endfunction

  // Reference: the top 10 phase bits pick one of 1024 bins on the full circle, sampled at bin centre.
  function automatic void model_sc(input logic [23:0] ph, output longint s, output longint c);
    real ang;
    ang = (real'(int'(ph >> 14)) + 0.5) * 2.0 * PI / 1024.0;
    s = rnd(32767.0 * $sin(ang));
    c = rnd(32767.0 * $cos(ang));
  endfunction

  typedef struct {
    logic [23:0] ph0;
    logic [23:0] ph1;
    int          due;
  } item_t;

  localparam logic [23:0] CF [2] = '{24'h400000, 24'hFFFFFF};

  item_t       pend [$];
  item_t       it;
  logic [23:0] macc [2];
  logic [23:0] e_ph [2];
  longint      e_s [2];
  longint      e_c [2];
  logic        e_v;
  int          cyc = 0;
  int          rst_cnt = 0;
  int          seen_rst = 0;

  always @(negedge rst_n) rst_cnt++;

  // Compare outputs of the last posedge, then log the inputs the next posedge will sample.
  always @(negedge clk) begin
    cyc++;
    if (rst_cnt != seen_rst || !rst_n) begin
      seen_rst = rst_cnt;
      pend.delete();
      for (int i = 0; i < 2; i++) begin
        macc[i] = '0; e_ph[i] = '0; e_s[i] = 0; e_c[i] = 0;
      end
    end
    if (chk_on) begin
      e_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        it = pend.pop_front();
        e_v = 1'b1;
        e_ph[0] = it.ph0;
        e_ph[1] = it.ph1;
        for (int i = 0; i < 2; i++) model_sc(e_ph[i], e_s[i], e_c[i]);
      end
      for (int i = 0; i < 2; i++) begin
        string nm;
        nm = (i == 0) ? "dut" : "dut_w";
        check({nm, ".known"}, longint'($isunknown({v_o[i], ph_o[i], s_o[i], c_o[i]})), 0);
        check({nm, ".valid"}, longint'(v_o[i]), longint'(e_v));
        check({nm, ".phase"}, longint'(ph_o[i]), longint'(e_ph[i]));
        check({nm, ".sin"}, longint'(s_o[i]), e_s[i]);
        check({nm, ".cos"}, longint'(c_o[i]), e_c[i]);
      end
    end
    if (rst_n && clr) begin
      pend.delete();
      macc[0] = '0;
      macc[1] = '0;
    end else if (rst_n && en) begin
      pend.push_back('{macc[0], macc[1], cyc + 4});
      for (int i = 0; i < 2; i++) macc[i] = macc[i] + CF[i] + freq_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  longint ms, mc;
  int     npulse;
  int     pt [2];
  logic [23:0] pph [2];
  longint exp_s1 [4] = '{101, 32767, -101, -32767};
  longint exp_c1 [4] = '{32767, -101, -32767, 101};

  initial begin
    model_sc(24'h000000, ms, mc); check("model_q0_sin", ms, 101);    check("model_q0_cos", mc, 32767);
    model_sc(24'h400000, ms, mc); check("model_q1_sin", ms, 32767);  check("model_q1_cos", mc, -101);
    model_sc(24'h800000, ms, mc); check("model_q2_sin", ms, -101);   check("model_q2_cos", mc, -32767);
    model_sc(24'hC00000, ms, mc); check("model_q3_sin", ms, -32767); check("model_q3_cos", mc, 101);
    model_sc(24'hFFFFFF, ms, mc); check("model_wrap_sin", ms, -101); check("model_wrap_cos", mc, 32767);

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_valid", longint'(bus_a.valid_o), 0);
    check("rst_phase", longint'(bus_a.phase_o), 0);
    check("rst_sin", longint'(bus_a.sin_o), 0);
    check("rst_cos", longint'(bus_a.cos_o), 0);

    // Constant en, nominal step: quarter-turn per sample.
    rst_n = 1'b1; en = 1'b1; freq_err = '0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      check("t1_valid", longint'(bus_a.valid_o), (t >= 4) ? 1 : 0);
      if (t >= 4) begin
        check("t1_phase", longint'(bus_a.phase_o), longint'(24'((t - 4) * 24'h400000)));
        check("t1_sin", longint'(bus_a.sin_o), exp_s1[(t - 4) % 4]);
        check("t1_cos", longint'(bus_a.cos_o), exp_c1[(t - 4) % 4]);
      end
    end

    // Correction cancels the centre step.
    tick(); clr = 1'b1; en = 1'b0;
    tick(); clr = 1'b0; en = 1'b1; freq_err = 24'hC00000;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t >= 4) begin
        check("t2_valid", longint'(bus_a.valid_o), 1);
        check("t2_phase", longint'(bus_a.phase_o), 0);
        check("t2_sin", longint'(bus_a.sin_o), 101);
        check("t2_cos", longint'(bus_a.cos_o), 32767);
      end
    end

    // Sparse en: one pulse per en, three cycles later.
    tick(); clr = 1'b1; en = 1'b0; freq_err = '0;
    npulse = 0;
    for (int t = 0; t <= 11; t++) begin
      tick();
      if (bus_a.valid_o) begin
        if (npulse < 2) begin pt[npulse] = t; pph[npulse] = bus_a.phase_o; end
        npulse++;
      end
      clr = 1'b0;
      en = (t == 0 || t == 3);
    end
    check("t3_pulses", npulse, 2);
    check("t3_t0", pt[0], 4);
    check("t3_ph0", longint'(pph[0]), 0);
    check("t3_t1", pt[1], 7);
    check("t3_ph1", longint'(pph[1]), 24'h400000);

    // clr with en flushes three in-flight samples.
    npulse = 0;
    for (int t = 0; t <= 12; t++) begin
      tick();
      if (bus_a.valid_o) begin
        if (npulse < 1) begin pt[0] = t; pph[0] = bus_a.phase_o; end
        npulse++;
      end
      clr = (t == 0 || t == 4);
      en = (t >= 1 && t <= 5);
    end
    check("t4_pulses", npulse, 1);
    check("t4_time", pt[0], 9);
    check("t4_phase", longint'(pph[0]), 0);

    // Wrapping accumulator on the all-ones centre step.
    for (int t = 0; t <= 7; t++) begin
      tick();
      if (t == 5) begin
        check("t5_ph0", longint'(bus_w.phase_o), 0);
        check("t5_sin0", longint'(bus_w.sin_o), 101);
      end else if (t == 6) begin
        check("t5_ph1", longint'(bus_w.phase_o), 24'hFFFFFF);
        check("t5_sin1", longint'(bus_w.sin_o), -101);
        check("t5_cos1", longint'(bus_w.cos_o), 32767);
      end else if (t == 7) begin
        check("t5_ph2", longint'(bus_w.phase_o), 24'hFFFFFE);
        check("t5_sin2", longint'(bus_w.sin_o), -101);
      end
      clr = (t == 0);
      en = (t >= 1);
    end

    // Asynchronous reset mid-stream.
    repeat (3) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid", longint'(bus_a.valid_o), 0);
    check("t6_valid_w", longint'(bus_w.valid_o), 0);
    check("t6_phase", longint'(bus_a.phase_o), 0);
    check("t6_sin", longint'(bus_a.sin_o), 0);
    check("t6_cos", longint'(bus_a.cos_o), 0);
    tick();
    tick(); rst_n = 1'b1; en = 1'b0;
    npulse = 0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (bus_a.valid_o) begin
        if (npulse < 1) begin pt[0] = t; pph[0] = bus_a.phase_o; end
        npulse++;
      end
      en = (t == 2);
    end
    check("t6_pulses", npulse, 1);
    check("t6_time", pt[0], 6);
    check("t6_phase0", longint'(pph[0]), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
